// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for the core's fetch stage. A fetch request
// (byte PC) is accepted over a valid/ready handshake. The 32-bit instruction
// word is returned LATENCY cycles later over a valid/ready response channel.
// Fetches that are misaligned or fall outside [BASE, BASE + 4*DEPTH) are
// answered with rsp_fault=1 and a zero instruction word. A write-only
// preload port fills the backing array at any time.
//
// Parameters:
//   BASE     byte address of word 0 (the core's reset PC)
//   DEPTH    number of 32-bit words; power of two, >= 2
//   LATENCY  cycles from request accept to rsp_valid; 1..7
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   req_valid    fetch request valid
//   req_ready    responder can accept a request this cycle
//   req_addr     fetch byte address (PC), sampled only at accept
//   rsp_valid    response valid
//   rsp_ready    core accepts the response
//   rsp_inst     instruction word (0 on a fault)
//   rsp_fault    misaligned or out-of-range fetch
//   load_en      preload write strobe
//   load_idx     preload word index
//   load_data    preload word
//   req_count    accepted-request counter, wraps
//   fault_count  faulted-request counter, saturates at 16'hFFFF
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_fault,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data,
    output logic [31:0]              req_count,
    output logic [15:0]              fault_count
);

    localparam int          AW    = $clog2(DEPTH);
    // One past the last valid byte address, kept at full 64-bit width so
    // addresses with upper bits set are never aliased into range.
    localparam logic [63:0] LIMIT = BASE + (64'(DEPTH) << 2);
    localparam bit          LAT1  = (LATENCY == 1);
    // WAIT counts down from LATENCY-2 to 0, then RESP is entered.
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              pend_fault_reg;
    logic [AW-1:0]     pend_idx_reg;
    logic              rsp_valid_reg;
    logic              rsp_fault_reg;
    logic [31:0]       rsp_inst_reg;
    logic [31:0]       req_count_reg;
    logic [15:0]       fault_count_reg;

    logic              accept;
    logic              enter_resp;
    logic              rd_from_req;
    logic              req_fault;
    logic [AW-1:0]     req_idx;
    logic              rd_fault;
    logic [AW-1:0]     rd_idx;

    logic [31:0]       mem [DEPTH];

    // Decode of the incoming address; only meaningful on an accept.
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (req_addr >= LIMIT);
    assign req_idx   = AW'((req_addr - BASE) >> 2);

    // With LATENCY=1 the accept edge is also the edge entering RESP, so the
    // read must use the live request rather than the pending registers.
    assign rd_fault = rd_from_req ? req_fault : pend_fault_reg;
    assign rd_idx   = rd_from_req ? req_idx   : pend_idx_reg;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        req_ready   = 1'b0;
        accept      = 1'b0;
        enter_resp  = 1'b0;
        rd_from_req = 1'b0;

        case (state_reg)
            IDLE:    req_ready = 1'b1;
            WAIT:    req_ready = 1'b0;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
        endcase

        accept = req_valid && req_ready;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LAT1) begin
                        state_next  = RESP;
                        enter_resp  = 1'b1;
                        rd_from_req = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        if (LAT1) begin
                            state_next  = RESP;
                            enter_resp  = 1'b1;
                            rd_from_req = 1'b1;
                        end else begin
                            state_next = WAIT;
                            cnt_next   = CNT_INIT;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 3'd0;
            pend_fault_reg  <= 1'b0;
            pend_idx_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_fault_reg   <= 1'b0;
            rsp_inst_reg    <= 32'd0;
            req_count_reg   <= 32'd0;
            fault_count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (accept) begin
                pend_fault_reg <= req_fault;
                pend_idx_reg   <= req_idx;
                req_count_reg  <= req_count_reg + 32'd1;
                if (req_fault && (fault_count_reg != 16'hFFFF)) begin
                    fault_count_reg <= fault_count_reg + 16'd1;
                end
            end

            // The array is read on the edge entering RESP. Because the load
            // port writes with a non-blocking assignment on the same edge,
            // a same-edge load to this index returns the old word.
            if (enter_resp) begin
                rsp_valid_reg <= 1'b1;
                rsp_fault_reg <= rd_fault;
                rsp_inst_reg  <= rd_fault ? 32'd0 : mem[rd_idx];
            end else if ((state_reg == RESP) && rsp_ready) begin
                rsp_valid_reg <= 1'b0;
                rsp_fault_reg <= 1'b0;
                rsp_inst_reg  <= 32'd0;
            end
        end
    end

    // Backing store: deliberately not reset so preloaded code survives rst.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_fault   = rsp_fault_reg;
    assign rsp_inst    = rsp_inst_reg;
    assign req_count   = req_count_reg;
    assign fault_count = fault_count_reg;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LAT  = 2;

    localparam logic [31:0] I0   = 32'h0010_0093;
    localparam logic [31:0] I1   = 32'h0000_8067;
    localparam logic [31:0] OLD5 = 32'h0050_0513;
    localparam logic [31:0] NEW5 = 32'h00A0_0593;
    localparam logic [31:0] LAST = 32'hDEAD_BEEF;
    localparam logic [31:0] AUXW = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // main instance (defaults: DEPTH=1024, LATENCY=2)
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_fault;
    logic [63:0] req_addr = 64'd0;
    logic [31:0] rsp_inst, req_count, load_data = 32'd0;
    logic [15:0] fault_count;
    logic        load_en = 1'b0;
    logic [9:0]  load_idx = 10'd0;

    // short-latency instance (LATENCY=1, DEPTH=16)
    logic        req_valid_s = 1'b0, req_ready_s, rsp_valid_s, rsp_ready_s = 1'b1, rsp_fault_s;
    logic [63:0] req_addr_s = 64'd0;
    logic [31:0] rsp_inst_s, req_count_s;
    logic [15:0] fault_count_s;

    // long-latency instance (LATENCY=7, DEPTH=16)
    logic        req_valid_l = 1'b0, req_ready_l, rsp_valid_l, rsp_ready_l = 1'b1, rsp_fault_l;
    logic [63:0] req_addr_l = 64'd0;
    logic [31:0] rsp_inst_l, req_count_l;
    logic [15:0] fault_count_l;

    // aux instances share one preload port
    logic        load_en_x = 1'b0;
    logic [3:0]  load_idx_x = 4'd0;
    logic [31:0] load_data_x = 32'd0;

    imem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_fault(rsp_fault), .load_en(load_en),
        .load_idx(load_idx), .load_data(load_data), .req_count(req_count),
        .fault_count(fault_count)
    );

    imem_responder #(.BASE(BASE), .DEPTH(16), .LATENCY(1)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_ready(req_ready_s),
        .req_addr(req_addr_s), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready_s),
        .rsp_inst(rsp_inst_s), .rsp_fault(rsp_fault_s), .load_en(load_en_x),
        .load_idx(load_idx_x), .load_data(load_data_x), .req_count(req_count_s),
        .fault_count(fault_count_s)
    );

    imem_responder #(.BASE(BASE), .DEPTH(16), .LATENCY(7)) dut_l (
        .clk(clk), .rst(rst), .req_valid(req_valid_l), .req_ready(req_ready_l),
        .req_addr(req_addr_l), .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready_l),
        .rsp_inst(rsp_inst_l), .rsp_fault(rsp_fault_l), .load_en(load_en_x),
        .load_idx(load_idx_x), .load_data(load_data_x), .req_count(req_count_l),
        .fault_count(fault_count_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_req = 32'd0;
    logic [15:0] exp_fault = 16'd0;
    bit          fresh = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: samples after inputs have settled, well away from posedge.
    always @(negedge clk) begin
        #2;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual inst=%h fault=%b required=no response", rsp_inst, rsp_fault);
            end else begin
                if (fresh) begin
                    total++;
                    if (cyc != q[0].due) begin
                        bad++;
                        $display("FAIL rsp_latency actual cycle=%0d required=%0d", cyc, q[0].due);
                    end
                end
                total++;
                if (rsp_inst !== q[0].inst || rsp_fault !== q[0].fault) begin
                    bad++;
                    $display("FAIL rsp_data actual inst=%h fault=%b required inst=%h fault=%b",
                             rsp_inst, rsp_fault, q[0].inst, q[0].fault);
                end else if (rsp_ready) begin
                    $display("rsp  inst=%h fault=%b cycle=%0d", rsp_inst, rsp_fault, cyc);
                end
                if (rsp_ready) void'(q.pop_front());
            end
            fresh = rsp_ready;
        end else begin
            fresh = 1'b1;
        end
    end

    // Called at a negedge; returns at the negedge following the accept.
    task automatic fetch(input logic [63:0] a, input logic [31:0] ei, input logic ef);
        int   n;
        exp_t e;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL fetch_accept addr=%h actual req_ready=%b required=1", a, req_ready);
        end else begin
            e.inst  = ei;
            e.fault = ef;
            e.due   = cyc + LAT;
            q.push_back(e);
            exp_req++;
            if (ef && exp_fault != 16'hFFFF) exp_fault++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 64'h0;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_idx  = 10'(idx);
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic drain_and_count(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 64'(q.size()), 64'd0);
        @(negedge clk);
        chk({tag, "_req_count"}, 64'(req_count), 64'(exp_req));
        chk({tag, "_fault_count"}, 64'(fault_count), 64'(exp_fault));
    endtask

    initial begin
        int c;
        int c0;

        // reset state and preload (loads work while rst=0)
        @(negedge clk);
        load(0, I0);
        load(1, I1);
        load(5, OLD5);
        load(1023, LAST);
        load_en_x = 1'b1; load_idx_x = 4'd3; load_data_x = AUXW;
        @(negedge clk);
        load_en_x = 1'b0;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_inst", 64'(rsp_inst), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_req_count", 64'(req_count), 64'd0);
        chk("reset_fault_count", 64'(fault_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: two back-to-back good fetches
        fetch(BASE, I0, 1'b0);
        fetch(BASE + 64'd4, I1, 1'b0);
        drain_and_count("t1");

        // 2: faults and range boundaries
        fetch(BASE + 64'd2, 32'd0, 1'b1);
        drain_and_count("t2a");
        fetch(64'h7FFF_FFFC, 32'd0, 1'b1);
        fetch(64'h8000_1000, 32'd0, 1'b1);
        drain_and_count("t2b");
        fetch(64'h8000_0FFC, LAST, 1'b0);
        fetch(64'h1_8000_0000, 32'd0, 1'b1);
        drain_and_count("t2c");

        // 3: backpressure, then same-cycle handoff
        rsp_ready = 1'b0;
        fetch(BASE + 64'd4, I1, 1'b0);
        c = 0;
        while (!rsp_valid && c < 20) begin @(negedge clk); c++; end
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        c0 = cyc;
        fetch(BASE, I0, 1'b0);
        chk("handoff_same_cycle", 64'(cyc - c0), 64'd1);
        drain_and_count("t3");

        // 4a: asynchronous reset while a response is being held
        rsp_ready = 1'b0;
        fetch(BASE, I0, 1'b0);
        c = 0;
        while (!rsp_valid && c < 20) begin @(negedge clk); c++; end
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        exp_req = 32'd0;
        exp_fault = 16'd0;
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_rsp_inst", 64'(rsp_inst), 64'd0);
        chk("async_rst_req_count", 64'(req_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;

        // 4b: reset while in WAIT drops the request
        fetch(BASE + 64'd4, I1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        exp_req = 32'd0;
        chk("wait_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("wait_rst_req_count", 64'(req_count), 64'd0);
        fetch(BASE, I0, 1'b0);
        drain_and_count("t4");

        // 5: same-edge load is not visible, later loads are
        fetch(BASE + 64'h14, OLD5, 1'b0);
        load(5, NEW5);
        fetch(BASE + 64'h14, NEW5, 1'b0);
        drain_and_count("t5");

        // 6a: LATENCY=7 instance, back-to-back
        req_valid_l = 1'b1;
        req_addr_l  = BASE + 64'd12;
        #1;
        chk("l7_req_ready_idle", 64'(req_ready_l), 64'd1);
        repeat (2) begin
            @(negedge clk);
            c = 1;
            while (!rsp_valid_l && c < 20) begin @(negedge clk); c++; end
            chk("l7_latency", 64'(c), 64'd7);
            chk("l7_inst", 64'(rsp_inst_l), 64'(AUXW));
        end
        req_valid_l = 1'b0;
        @(negedge clk);
        chk("l7_req_count", 64'(req_count_l), 64'd2);

        // 6b: LATENCY=1 instance, then fault-counter saturation
        req_valid_s = 1'b1;
        req_addr_s  = BASE + 64'd12;
        @(negedge clk);
        chk("l1_rsp_valid", 64'(rsp_valid_s), 64'd1);
        chk("l1_inst", 64'(rsp_inst_s), 64'(AUXW));
        @(negedge clk);
        chk("l1_b2b_valid", 64'(rsp_valid_s), 64'd1);
        chk("l1_req_count", 64'(req_count_s), 64'd2);
        req_addr_s = BASE + 64'd1;
        repeat (65534) @(negedge clk);
        chk("sat_below", 64'(fault_count_s), 64'hFFFE);
        chk("sat_rsp_fault", 64'(rsp_fault_s), 64'd1);
        chk("sat_rsp_inst", 64'(rsp_inst_s), 64'd0);
        repeat (3) @(negedge clk);
        chk("sat_held", 64'(fault_count_s), 64'hFFFF);
        chk("sat_req_count", 64'(req_count_s), 64'd65539);
        req_valid_s = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that serves fetch requests from the core's fetch stage. It accepts a PC-addressed request over a valid/ready handshake and returns the 32-bit instruction word after a fixed, parameterised latency. It flags misaligned or out-of-range fetches as faults and provides a preload port that the testbench and loader use to fill memory. It sits between the core's PC/inst interface and the backing instruction storage.

Parameters:
BASE, 64'h80000000, byte address of word 0; this is the core's reset PC.
DEPTH, 1024, number of 32-bit words stored; power of two, at least 2.
LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..7.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
req_valid  in  1  fetch request valid.
req_ready  out  1  responder can accept a request this cycle.
req_addr  in  64  fetch byte address (PC).
rsp_valid  out  1  response valid.
rsp_ready  in  1  core accepts the response.
rsp_inst  out  32  instruction word; 0 when rsp_fault=1.
rsp_fault  out  1  misaligned or out-of-range fetch.
load_en  in  1  preload write strobe.
load_idx  in  $clog2(DEPTH)  preload word index.
load_data  in  32  preload word.
req_count  out  32  accepted-request counter; wraps modulo 2^32.
fault_count  out  16  faulted-request counter; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - state←IDLE; rsp_valid, rsp_fault, rsp_inst, req_count, fault_count ← 0.
  - The memory array is not cleared.
  - Any in-flight request is dropped and no response is emitted for it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=rsp_ready (same-cycle handoff).
- Accept: the handshake fires when req_valid && req_ready.
  - The responder latches req_addr and computes fault = (addr[1:0]≠0) || addr<BASE || addr≥BASE+4*DEPTH.
  - Range compare uses full 64-bit unsigned arithmetic, with no truncation of the upper bits.
  - Word index = (addr−BASE)[$clog2(DEPTH)+1:2].
  - req_count increments; fault_count increments if fault and not already saturated.
- Latency: a request accepted at edge t produces rsp_valid=1 in the cycle after edge t+LATENCY−1.
  - Equivalently, rsp_valid is seen LATENCY cycles after the accept cycle.
  - LATENCY=1: the FSM goes IDLE→RESP directly.
  - LATENCY>1: the FSM goes IDLE→WAIT with counter=LATENCY−2, decrements each cycle, and enters RESP when the counter is 0.
- Read sampling: the array is read on the edge entering RESP and registered into rsp_inst.
  - A load_en write to the same index on that same edge is not visible; the old data is returned (read-before-write).
  - Loads on earlier edges are visible.
- RESP: rsp_valid, rsp_inst and rsp_fault hold stable until rsp_ready=1.
  - rsp_ready=1 with req_valid=0: return to IDLE; rsp_valid←0.
  - rsp_ready=1 with req_valid=1: accept the new request in the same cycle and proceed to WAIT/RESP per LATENCY.
  - Sustained throughput is one response per LATENCY cycles.
- Fault response: rsp_inst=0, rsp_fault=1; no array read occurs.
- load_en is accepted in any state, including during reset deassertion edges after rst=1.
  - It has no handshake and does not affect the FSM.
- Writes on load_idx are always in range by construction of the port width.
- req_addr is sampled only at accept; changes while not ready are ignored.

Test Plan:
1. Preload idx0=32'h00100093, idx1=32'h00008067; request 0x80000000 then 0x80000004 with rsp_ready=1 → rsp_inst=00100093 then 00008067 at 2-cycle spacing; req_count=2.
2. Request 0x80000002 → rsp_fault=1, rsp_inst=0, fault_count=1. Request 0x7FFFFFFC and 0x80001000 (DEPTH=1024) → both fault, fault_count=3.
3. Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid and rsp_inst stable and req_ready=0. Then rsp_ready=1 with req_valid=1 → same-cycle accept, next response 2 cycles later.
4. Drive rst=0 while in WAIT → rsp_valid=0 immediately (asynchronously), no stale response after rst=1. Preloaded contents survive the reset.
5. load_en to idx5 on the edge entering RESP for a fetch of 0x80000014 → old word returned. Refetch → new word.
6. LATENCY=1 and LATENCY=7 builds: back-to-back fetches → rsp_valid appears 1 and 7 cycles after accept respectively. Fault counter saturates at 16'hFFFF under repeated faults.
